// File: rtl/phase_pkg.sv
// Shared constants and FSM encoding for the phase-to-degrees converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package phase_pkg;

    // Full circle in result units (0.1 degree per LSB).
    localparam int SCALE     = 3600;
    // Result width; 2**Q_WIDTH must exceed SCALE.
    localparam int Q_WIDTH   = 12;
    // Width of the gate / window clock counters.
    localparam int CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per step, MSB first.
// Latency: 1 cycle to load, then one quotient bit per step cycle.
// Backpressure: none; the caller sequences load/step and holds denominator stable.
//
// Ports: load primes the partial remainder with numerator[NUM_W-1 -: DEN_W]
// and keeps the low Q_W numerator bits to shift in; step performs one
// shift/compare/subtract; quotient/remainder are the running results.
module serial_divider #(
    parameter int DEN_W = 32,
    parameter int Q_W   = 12,
    parameter int NUM_W = DEN_W + Q_W
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic [Q_W-1:0]   quotient,
    output logic [DEN_W-1:0] remainder
);

    // Numerator bits still waiting to be shifted into the remainder.
    logic [Q_W-1:0]   low_q;
    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;
    logic             q_bit;

    // The trial value is one bit wider than the remainder so the compare
    // never loses the bit shifted out of the top.
    always_comb begin
        trial = {remainder, low_q[Q_W-1]};
        q_bit = (trial >= {1'b0, denominator});
        // When q_bit is set, trial < 2*denominator, so the difference fits
        // in DEN_W bits and modular subtraction on the low bits is exact.
        diff  = trial[DEN_W-1:0] - denominator;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            remainder <= '0;
            low_q     <= '0;
            quotient  <= '0;
        end else if (load) begin
            remainder <= numerator[NUM_W-1 -: DEN_W];
            low_q     <= numerator[Q_W-1:0];
            quotient  <= '0;
        end else if (step) begin
            remainder <= q_bit ? diff : trial[DEN_W-1:0];
            low_q     <= {low_q[Q_W-2:0], 1'b0};
            quotient  <= {quotient[Q_W-2:0], q_bit};
        end
    end

endmodule

// File: rtl/phase_deg_calc.sv
// Converts a window/gate clock-count pair to phase: floor(diff_cnt*SCALE/gate_cnt).
// Latency: fixed Q_WIDTH+2 cycles from the start-sampling edge to phase_valid.
// Backpressure: none; start is only accepted while idle (busy=0), otherwise dropped.
//
// Ports: sys_clk/rst_n clock and async active-low reset; start + diff_cnt/gate_cnt
// request a conversion; busy marks a conversion in flight; phase_valid strobes
// for one cycle as phase_deg/phase_err take their new (held) values.
module phase_deg_calc #(
    parameter int SCALE   = phase_pkg::SCALE,
    parameter int Q_WIDTH = phase_pkg::Q_WIDTH
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [phase_pkg::CNT_WIDTH-1:0] diff_cnt,
    input  logic [phase_pkg::CNT_WIDTH-1:0] gate_cnt,
    output logic                           busy,
    output logic [Q_WIDTH-1:0]             phase_deg,
    output logic                           phase_valid,
    output logic                           phase_err
);

    localparam int CW     = phase_pkg::CNT_WIDTH;
    localparam int NUM_W  = CW + Q_WIDTH;
    localparam int STEP_W = $clog2(Q_WIDTH + 1);

    phase_pkg::state_t state_q, state_nxt;

    logic [CW-1:0]      diff_q, gate_q;
    logic [NUM_W-1:0]   num_q;
    logic               err_q;      // operands invalid
    logic               zero_q;     // result forced to 0 (invalid, or exactly 360.0 deg)
    logic [STEP_W-1:0]  step_cnt_q; // 0: load cycle, 1..Q_WIDTH: divide steps
    logic [Q_WIDTH-1:0] res_deg_q;
    logic               res_err_q;

    logic               div_load, div_step, div_last;
    logic [Q_WIDTH-1:0] div_quot;
    // The floor result only needs the quotient.
    logic [CW-1:0]      div_rem_unused;

    always_comb begin
        div_load = (state_q == phase_pkg::ST_DIV) && (step_cnt_q == '0);
        div_step = (state_q == phase_pkg::ST_DIV) && (step_cnt_q != '0);
        div_last = (step_cnt_q == STEP_W'(Q_WIDTH));
    end

    serial_divider #(
        .DEN_W (CW),
        .Q_W   (Q_WIDTH),
        .NUM_W (NUM_W)
    ) u_div (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .load        (div_load),
        .step        (div_step),
        .numerator   (num_q),
        .denominator (gate_q),
        .quotient    (div_quot),
        .remainder   (div_rem_unused)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= phase_pkg::ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic. DIV spends one cycle loading and Q_WIDTH cycles
    // stepping, which together with MUL gives the fixed Q_WIDTH+2 latency.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            phase_pkg::ST_IDLE: if (start) state_nxt = phase_pkg::ST_MUL;
            phase_pkg::ST_MUL:  state_nxt = phase_pkg::ST_DIV;
            phase_pkg::ST_DIV:  if (div_last) state_nxt = phase_pkg::ST_DONE;
            phase_pkg::ST_DONE: state_nxt = phase_pkg::ST_IDLE;
            default:            state_nxt = phase_pkg::ST_IDLE;
        endcase
    end

    // Datapath registers. Operands are only captured in IDLE, so changes on
    // the inputs during a conversion cannot disturb it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= '0;
            gate_q     <= '0;
            num_q      <= '0;
            err_q      <= 1'b0;
            zero_q     <= 1'b0;
            step_cnt_q <= '0;
            res_deg_q  <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state_q)
                phase_pkg::ST_IDLE: begin
                    if (start) begin
                        diff_q <= diff_cnt;
                        gate_q <= gate_cnt;
                    end
                end
                phase_pkg::ST_MUL: begin
                    num_q      <= {{Q_WIDTH{1'b0}}, diff_q} * NUM_W'(SCALE);
                    err_q      <= (gate_q == '0) || (diff_q > gate_q);
                    // diff == gate is a full turn, which wraps to 0 without error.
                    zero_q     <= (gate_q == '0) || (diff_q >= gate_q);
                    step_cnt_q <= '0;
                end
                phase_pkg::ST_DIV: begin
                    if (!div_last) begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end
                phase_pkg::ST_DONE: begin
                    res_deg_q <= zero_q ? '0 : div_quot;
                    res_err_q <= err_q;
                end
                default: ;
            endcase
        end
    end

    // Outputs. During DONE the final quotient is presented directly so the
    // result is visible on the same cycle as the strobe; the held copy takes
    // over from the following cycle.
    always_comb begin
        busy        = (state_q != phase_pkg::ST_IDLE);
        phase_valid = (state_q == phase_pkg::ST_DONE);
        if (state_q == phase_pkg::ST_DONE) begin
            phase_deg = zero_q ? '0 : div_quot;
            phase_err = err_q;
        end else begin
            phase_deg = res_deg_q;
            phase_err = res_err_q;
        end
    end

endmodule

// File: tb/tb_phase_deg_calc.sv
// Scoreboard bench for phase_deg_calc: directed operand pairs with hand-computed results.
// Latency: expectations carry the cycle on which phase_valid must appear.
// Backpressure: n/a.
module tb_phase_deg_calc;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] diff_cnt, gate_cnt;
    logic        busy, phase_valid, phase_err;
    logic [11:0] phase_deg;

    typedef struct {
        logic [11:0] deg;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    phase_deg_calc dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .start       (start),
        .diff_cnt    (diff_cnt),
        .gate_cnt    (gate_cnt),
        .busy        (busy),
        .phase_deg   (phase_deg),
        .phase_valid (phase_valid),
        .phase_err   (phase_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Number of rising edges seen so far.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: every phase_valid strobe must match the oldest expectation.
    always @(negedge sys_clk) begin
        if (phase_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got phase_valid=%b deg=%0d, expected no strobe (cycle %0d)",
                         phase_valid, phase_deg, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("phase_deg", 32'(phase_deg), 32'(e.deg));
                check("phase_err", 32'(phase_err), 32'(e.err));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Launch one conversion; returns at the falling edge after the sampling edge.
    task automatic issue(input logic [31:0] d, input logic [31:0] g,
                         input logic [11:0] ed, input logic ee, input bit expect_result);
        exp_t e;
        @(negedge sys_clk);
        diff_cnt = d;
        gate_cnt = g;
        start    = 1'b1;
        if (expect_result) begin
            e.deg = ed;
            e.err = ee;
            e.cyc = cyc + 1 + 14;
            sb.push_back(e);
        end
        @(negedge sys_clk);
        start    = 1'b0;
        // Disturb the inputs; the captured operands must be used.
        diff_cnt = ~d;
        gate_cnt = ~g;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b after %0d cycles, expected 0", busy, n);
        end
        @(negedge sys_clk);
    endtask

    task automatic run(input logic [31:0] d, input logic [31:0] g,
                       input logic [11:0] ed, input logic ee);
        issue(d, g, ed, ee, 1'b1);
        wait_idle();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        diff_cnt = '0;
        gate_cnt = '0;
        repeat (3) @(negedge sys_clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(phase_valid), 32'd0);
        check("reset_deg", 32'(phase_deg), 32'd0);
        check("reset_err", 32'(phase_err), 32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Directed vectors: diff, gate, expected deg (0.1 deg), expected err.
        run(32'd25_000_000, 32'd100_000_000, 12'd900, 1'b0);
        run(32'd1, 32'd7, 12'd514, 1'b0);
        run(32'd1, 32'd3, 12'd1200, 1'b0);
        run(32'd7, 32'd0, 12'd0, 1'b1);
        run(32'd0, 32'd0, 12'd0, 1'b1);
        run(32'd1, 32'd3, 12'd1200, 1'b0);
        run(32'd101, 32'd100, 12'd0, 1'b1);
        run(32'd50, 32'd50, 12'd0, 1'b0);
        run(32'd0, 32'd100, 12'd0, 1'b0);
        run(32'd99, 32'd100, 12'd3564, 1'b0);
        run(32'd3, 32'd4, 12'd2700, 1'b0);
        run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 12'd3599, 1'b0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 12'd0, 1'b1);

        // Start re-pulsed mid-conversion (cycles 3 and 13) and on the strobe cycle:
        // only the first operands may produce a result.
        issue(32'd1, 32'd7, 12'd514, 1'b0, 1'b1);
        repeat (2) @(negedge sys_clk);
        diff_cnt = 32'd1;
        gate_cnt = 32'd3;
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        repeat (9) @(negedge sys_clk);
        diff_cnt = 32'd50;
        gate_cnt = 32'd100;
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        @(negedge sys_clk);
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        check("busy_after_done_start", 32'(busy), 32'd0);
        repeat (20) @(negedge sys_clk);
        check("held_deg_after_repulse", 32'(phase_deg), 32'd514);

        // Reset in the middle of the divide: no strobe, everything cleared.
        issue(32'd1, 32'd3, 12'd0, 1'b0, 1'b0);
        repeat (7) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(phase_valid), 32'd0);
        check("midreset_deg", 32'(phase_deg), 32'd0);
        check("midreset_err", 32'(phase_err), 32'd0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("post_reset_deg", 32'(phase_deg), 32'd0);
        run(32'd50, 32'd100, 12'd1800, 1'b0);
        check("held_deg_final", 32'(phase_deg), 32'd1800);

        repeat (5) @(negedge sys_clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_deg_calc.md
PHASE_DEG_CALC -- requirements
Module: phase_deg_calc

Interface
REQ-001 SCALE, default 3600, full-circle phase in result units (0.1 degree per LSB).
REQ-002 Q_WIDTH, default 12, result width (must satisfy 2^Q_WIDTH > SCALE).
REQ-003 sys_clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request: sample operands and begin a conversion.
REQ-006 diff_cnt  input  32  clock count during which the phase-difference window was high over one gate.
REQ-007 gate_cnt  input  32  clock count of that same gate (denominator).
REQ-008 busy  output  1  high from the cycle after start is accepted until phase_valid is asserted.
REQ-009 phase_deg  output  Q_WIDTH  last result, floor(diff_cnt*SCALE/gate_cnt), held until the next result.
REQ-010 phase_valid  output  1  one-cycle strobe when phase_deg and phase_err update.
REQ-011 phase_err  output  1  set with phase_valid when the operands are invalid; held until the next result.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-013 In IDLE, start=1 SHALL capture diff_cnt and gate_cnt into internal registers and move to MUL; start=0 SHALL keep the FSM in IDLE.
REQ-014 start asserted outside IDLE SHALL be ignored, with no capture and no queueing.
REQ-015 MUL SHALL register numerator = diff_cnt*SCALE at full width (32+Q_WIDTH bits, no truncation) and move to DIV.
REQ-016 DIV SHALL perform Q_WIDTH restoring-division steps, one per cycle, MSB first.
REQ-017 The 32-bit partial remainder SHALL be initialised to numerator[43:12].
REQ-018 Each step SHALL shift in the next lower numerator bit, compare against gate_cnt with a 33-bit compare, subtract if greater or equal, and emit one quotient bit.
REQ-019 After the last step the FSM SHALL go to DONE, which updates the outputs and returns to IDLE in one cycle.
REQ-020 Latency SHALL be fixed at Q_WIDTH+2 cycles: phase_valid is high exactly 14 cycles after the edge that sampled start, including the error cases.
REQ-021 Result rounding SHALL be truncation toward zero.
REQ-022 gate_cnt=0 SHALL give phase_err=1 and phase_deg=0.
REQ-023 diff_cnt>gate_cnt SHALL give phase_err=1 and phase_deg=0.
REQ-024 diff_cnt==gate_cnt SHALL give phase_err=0 and phase_deg=0 (360.0 degrees wraps to 0).
REQ-025 diff_cnt=0 with gate_cnt>0 SHALL give phase_deg=0 and phase_err=0.
REQ-026 The validity checks in REQ-022..REQ-024 SHALL be decided on the captured operands in MUL; the divider still runs, but its quotient is discarded.
REQ-027 busy SHALL be 0 in IDLE and 1 in MUL, DIV and DONE.
REQ-028 start and a DONE cycle cannot coincide in IDLE; start on the cycle phase_valid is high SHALL be ignored (the FSM is still in DONE).
REQ-029 Operand changes after capture SHALL NOT affect the result in progress.

Reset
REQ-030 rst_n low SHALL asynchronously force: FSM=IDLE, busy=0, phase_valid=0, phase_err=0, phase_deg=0, all internal registers 0.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion with no phase_valid strobe; the first start after release SHALL convert normally.

Structure
REQ-032 Package phase_pkg SHALL hold SCALE, Q_WIDTH, CNT_WIDTH=32 and the FSM state encoding.
REQ-033 The shift/compare/subtract datapath SHALL be a sub-module serial_divider (load, step, quotient, remainder ports), instantiated once.

Verification
REQ-034 diff_cnt=25_000_000, gate_cnt=100_000_000, start pulse -> phase_valid 14 cycles later, phase_deg=900, phase_err=0.
REQ-035 diff_cnt=1, gate_cnt=7 -> phase_deg=514; diff_cnt=1, gate_cnt=3 -> phase_deg=1200.
REQ-036 gate_cnt=0 -> phase_err=1, phase_deg=0; diff_cnt=101, gate_cnt=100 -> phase_err=1; diff_cnt=gate_cnt=50 -> phase_deg=0, phase_err=0.
REQ-037 start re-pulsed at cycles 3 and 13 of a conversion with different operands -> single phase_valid, result from the first operands only.
REQ-038 rst_n pulsed low at DIV step 5 -> no phase_valid, all outputs 0; next start with 50/100 -> phase_deg=1800 after 14 cycles.
